scan_rd_engine: RTL

Cache-line read engine for the scan AFU. It streams `num_lines` consecutive lines starting at `base_addr` as CCI-P c0 read requests, with flow control from c0TxAlmFull and a cap on outstanding reads. It returns each read response, registered and tagged with its line index, to the scan datapath. It sits directly upstream of the c0Tx channel that the AFU wrapper converts to MPF form, and directly downstream of the c0Rx response path.

---
 rtl/scan_rd_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/scan_rd_engine.sv
// scan_rd_engine: cache-line read engine for the scan AFU.
// Streams num_lines consecutive c0 read requests starting at base_addr,
// throttled by c0TxAlmFull and an outstanding-read window. Returns each
// read response, registered and tagged with its line index.
// Optional build macro: SCAN_RD_STALL_CNT_EN enables the stall_cycles counter.
module scan_rd_engine #(
  parameter int unsigned LINE_ADDR_W     = 42,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LINE_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]       num_lines,
  input  logic                   c0TxAlmFull,
  output logic                   rd_req_valid,
  output logic [LINE_ADDR_W-1:0] rd_req_addr,
  output logic [15:0]            rd_req_mdata,
  input  logic                   rsp_valid,
  input  logic [15:0]            rsp_mdata,
  input  logic [511:0]           rsp_data,
  output logic                   out_valid,
  output logic [511:0]           out_data,
  output logic [15:0]            out_line_idx,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       reqs_issued,
  output logic [CNT_W-1:0]       rsps_received,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [LINE_ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]       r_num;
  logic [OUT_W-1:0]       r_outstanding;
  logic [CNT_W-1:0]       r_reqs_issued;
  logic [CNT_W-1:0]       r_rsps_received;
  logic                   r_rd_req_valid;
  logic [LINE_ADDR_W-1:0] r_rd_req_addr;
  logic [15:0]            r_rd_req_mdata;
  logic                   r_out_valid;
  logic [511:0]           r_out_data;
  logic [15:0]            r_out_line_idx;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_launch;
  logic                   w_window_open;
  logic                   w_issue;
  logic                   w_accept;
  logic [CNT_W-1:0]       w_issue_idx;
  logic [CNT_W-1:0]       w_job_len;
  logic                   w_last_issue;
  logic                   w_last_rsp;
  logic [LINE_ADDR_W-1:0] w_issue_addr;
  logic [CNT_W-1:0]       w_reqs_next;
  logic [CNT_W-1:0]       w_rsps_next;
  logic [OUT_W-1:0]       w_out_next;

  // Issue/accept decisions and next counter values. The start cycle itself
  // may issue line 0 (using the unlatched inputs) so the first request
  // appears the cycle after start.
  always_comb begin
    w_launch      = (r_state == S_IDLE) && start;
    w_window_open = (r_outstanding < OUT_W'(MAX_OUTSTANDING));
    w_issue       = (w_launch && (num_lines != '0) && !c0TxAlmFull) ||
                    ((r_state == S_ISSUE) && !c0TxAlmFull && w_window_open);
    w_accept      = rsp_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    w_issue_idx   = w_launch ? '0 : r_reqs_issued;
    w_job_len     = w_launch ? num_lines : r_num;
    w_last_issue  = w_issue && ((w_issue_idx + CNT_W'(1)) == w_job_len);
    w_issue_addr  = (w_launch ? base_addr : r_base) + LINE_ADDR_W'(w_issue_idx);
    w_reqs_next   = w_issue ? (w_issue_idx + CNT_W'(1)) : w_issue_idx;
    w_rsps_next   = w_launch ? '0 : (r_rsps_received + CNT_W'(w_accept));
    w_last_rsp    = (w_rsps_next == r_num);
    w_out_next    = w_launch ? OUT_W'(w_issue)
                             : (r_outstanding + OUT_W'(w_issue) - OUT_W'(w_accept));
  end

  // Job FSM with registered request, response and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_base          <= '0;
      r_num           <= '0;
      r_outstanding   <= '0;
      r_reqs_issued   <= '0;
      r_rsps_received <= '0;
      r_rd_req_valid  <= 1'b0;
      r_rd_req_addr   <= '0;
      r_rd_req_mdata  <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_line_idx  <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_rd_req_valid  <= w_issue;
      r_out_valid     <= w_accept;
      r_outstanding   <= w_out_next;
      r_reqs_issued   <= w_reqs_next;
      r_rsps_received <= w_rsps_next;
      r_done          <= 1'b0;
      if (w_issue) begin
        r_rd_req_addr  <= w_issue_addr;
        r_rd_req_mdata <= w_issue_idx[15:0];
      end
      if (w_accept) begin
        r_out_data     <= rsp_data;
        r_out_line_idx <= rsp_mdata;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= base_addr;
            r_num  <= num_lines;
            if (num_lines == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= w_last_issue ? S_DRAIN : S_ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_last_issue) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last_rsp) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req_valid  = r_rd_req_valid;
  assign rd_req_addr   = r_rd_req_addr;
  assign rd_req_mdata  = r_rd_req_mdata;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_line_idx  = r_out_line_idx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign reqs_issued   = r_reqs_issued;
  assign rsps_received = r_rsps_received;

`ifdef SCAN_RD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Count ISSUE cycles where almost-full or the window blocked a request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (w_launch) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_ISSUE) && !w_issue) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
